// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mc_pkg
// Purpose  : Shared types and address-map constants for the DDR5 request
//            queue, its address decoder and the scheduler debug display.
// Contents : mc_req_t (raw trace request), mc_op_e (operation codes),
//            mc_decoded_t (request with address split into DRAM fields),
//            bit positions of every DRAM field inside the 34-bit address.
// Revision : 1.0  initial release
// ============================================================================
package mc_pkg;

  // DRAM field positions inside the 34-bit physical address.
  localparam int ROW_HI  = 33;
  localparam int ROW_LO  = 18;
  localparam int COLH_HI = 17;
  localparam int COLH_LO = 12;
  localparam int BANK_HI = 11;
  localparam int BANK_LO = 10;
  localparam int BG_HI   = 9;
  localparam int BG_LO   = 7;
  localparam int CH_BIT  = 6;
  localparam int COLL_HI = 5;
  localparam int COLL_LO = 2;

  // Encoding 3 is reserved; it is carried through untouched and the
  // scheduler treats it as a write.
  typedef enum logic [1:0] {
    RD     = 2'd0,
    WR     = 2'd1,
    IFETCH = 2'd2
  } mc_op_e;

  typedef struct packed {
    logic [3:0]  core;
    logic [31:0] req_time;
    logic [1:0]  operation;
    logic [33:0] address;
  } mc_req_t;

  typedef struct packed {
    logic [3:0]  core;
    logic [1:0]  operation;
    logic [31:0] req_time;
    logic [15:0] row;
    logic [1:0]  bank;
    logic [2:0]  bank_group;
    logic        channel;
    logic [9:0]  column;
  } mc_decoded_t;

endpackage
`default_nettype wire

// File: rtl/mc_request_queue_if.sv
`default_nettype none
// ============================================================================
// Interface: mc_request_queue_if
// Purpose  : Request-side and scheduler-side handshakes of the request queue.
// Modports : master - trace source / scheduler side (drives in_*, out_ready)
//            slave  - the queue (drives in_ready and all out_* signals)
// Signals  : in_valid/in_ready, in_core, in_req_time, in_operation,
//            in_address; out_valid/out_ready, out_core, out_operation,
//            out_req_time, out_row, out_bank, out_bank_group, out_channel,
//            out_column
// Revision : 1.0  initial release
// ============================================================================
interface mc_request_queue_if;

  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_core;
  logic [31:0] in_req_time;
  logic [1:0]  in_operation;
  logic [33:0] in_address;

  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_core;
  logic [1:0]  out_operation;
  logic [31:0] out_req_time;
  logic [15:0] out_row;
  logic [1:0]  out_bank;
  logic [2:0]  out_bank_group;
  logic        out_channel;
  logic [9:0]  out_column;

  modport master (
    output in_valid, in_core, in_req_time, in_operation, in_address, out_ready,
    input  in_ready, out_valid, out_core, out_operation, out_req_time, out_row,
           out_bank, out_bank_group, out_channel, out_column
  );

  modport slave (
    input  in_valid, in_core, in_req_time, in_operation, in_address, out_ready,
    output in_ready, out_valid, out_core, out_operation, out_req_time, out_row,
           out_bank, out_bank_group, out_channel, out_column
  );

endinterface
`default_nettype wire

// File: rtl/mc_addr_decode.sv
`default_nettype none
// ============================================================================
// Module   : mc_addr_decode
// Purpose  : Combinational split of a trace request into DRAM row, bank,
//            bank group, channel and column. Also used by the scheduler
//            debug display.
// Ports    : req (in, mc_req_t)      raw request
//            dec (out, mc_decoded_t) request with decoded address fields
// Revision : 1.0  initial release
// ============================================================================
module mc_addr_decode
  import mc_pkg::*;
(
  input  mc_req_t     req,
  output mc_decoded_t dec
);

  // Address bits [1:0] select bytes inside a beat and map to no DRAM field.
  logic w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^req.address[1:0];

  always_comb begin
    dec            = '0;
    dec.core       = req.core;
    dec.operation  = req.operation;
    dec.req_time   = req.req_time;
    dec.row        = req.address[ROW_HI:ROW_LO];
    dec.bank       = req.address[BANK_HI:BANK_LO];
    dec.bank_group = req.address[BG_HI:BG_LO];
    dec.channel    = req.address[CH_BIT];
    // The column is split around the bank/bank-group/channel bits.
    dec.column     = {req.address[COLH_HI:COLH_LO], req.address[COLL_HI:COLL_LO]};
  end

endmodule
`default_nettype wire

// File: rtl/mc_request_queue.sv
`default_nettype none
// ============================================================================
// Module   : mc_request_queue
// Purpose  : In-order request queue in front of the DDR5 command scheduler.
//            The head entry is offered only once cycle_count reaches
//            req_time + ARRIVAL_LAT; a head that is not yet eligible blocks
//            every younger entry. The head is presented already decoded.
// Params   : DEPTH (power of 2, >= 2), ARRIVAL_LAT
// Ports    : clock, reset (async, active high), cycle_count[63:0],
//            bus (mc_request_queue_if.slave), count, full, empty
//            With MC_REQQ_STATS_EN defined: stat_accepted[63:0],
//            stat_hiwater, stat_stall[31:0]
// Revision : 1.0  initial release
// ============================================================================
module mc_request_queue
  import mc_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ARRIVAL_LAT = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [63:0]            cycle_count,
  mc_request_queue_if.slave      bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
`ifdef MC_REQQ_STATS_EN
  ,
  output logic [63:0]            stat_accepted,
  output logic [$clog2(DEPTH):0] stat_hiwater,
  output logic [31:0]            stat_stall
`endif
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  mc_req_t            r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] w_count_next;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_out_valid;
  logic [63:0] w_release_time;
  mc_req_t     w_in_req;
  mc_req_t     w_head;
  mc_decoded_t w_head_dec;

  assign w_full  = (r_count == c_CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  assign w_in_req = {bus.in_core, bus.in_req_time, bus.in_operation, bus.in_address};
  assign w_head   = r_mem[r_rd_ptr];

  // Widened to 64 bits before the add so a req_time near 2^32 cannot wrap.
  assign w_release_time = {32'b0, w_head.req_time} + 64'(ARRIVAL_LAT);
  assign w_out_valid    = !w_empty && (cycle_count >= w_release_time);

  assign w_push = bus.in_valid && !w_full;
  assign w_pop  = w_out_valid && bus.out_ready;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + c_CNT_W'(1);
      2'b01:   w_count_next = r_count - c_CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Storage is cleared on reset so the payload outputs read zero while
  // reset is applied. Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_in_req;
        r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      r_count <= w_count_next;
    end
  end

  mc_addr_decode u_addr_decode (
    .req (w_head),
    .dec (w_head_dec)
  );

  assign bus.in_ready       = !w_full;
  assign bus.out_valid      = w_out_valid;
  assign bus.out_core       = w_head_dec.core;
  assign bus.out_operation  = w_head_dec.operation;
  assign bus.out_req_time   = w_head_dec.req_time;
  assign bus.out_row        = w_head_dec.row;
  assign bus.out_bank       = w_head_dec.bank;
  assign bus.out_bank_group = w_head_dec.bank_group;
  assign bus.out_channel    = w_head_dec.channel;
  assign bus.out_column     = w_head_dec.column;

  assign count = r_count;
  assign full  = w_full;
  assign empty = w_empty;

`ifdef MC_REQQ_STATS_EN
  logic [63:0]        r_stat_accepted;
  logic [c_CNT_W-1:0] r_stat_hiwater;
  logic [31:0]        r_stat_stall;

  // High-water mark follows the next count so it is current the cycle after
  // the push that set it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stat_accepted <= '0;
      r_stat_hiwater  <= '0;
      r_stat_stall    <= '0;
    end else begin
      if (w_push && (r_stat_accepted != '1)) begin
        r_stat_accepted <= r_stat_accepted + 64'd1;
      end
      if (w_count_next > r_stat_hiwater) begin
        r_stat_hiwater <= w_count_next;
      end
      if (bus.in_valid && w_full && (r_stat_stall != '1)) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end

  assign stat_accepted = r_stat_accepted;
  assign stat_hiwater  = r_stat_hiwater;
  assign stat_stall    = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_request_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_request_queue
// Purpose  : Directed self-checking bench for mc_request_queue
//            (DEPTH=16, ARRIVAL_LAT=2). Covers the optional statistics
//            outputs when MC_REQQ_STATS_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_mc_request_queue;
  import mc_pkg::*;

  logic        clock;
  logic        reset;
  logic [63:0] cycle_count;
  logic [4:0]  count;
  logic        full;
  logic        empty;
`ifdef MC_REQQ_STATS_EN
  logic [63:0] stat_accepted;
  logic [4:0]  stat_hiwater;
  logic [31:0] stat_stall;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] sb[$];   // expected row of each queued entry, oldest first
  int next_row;

  mc_request_queue_if bus_if ();

  mc_request_queue #(
    .DEPTH       (16),
    .ARRIVAL_LAT (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cycle_count (cycle_count),
    .bus         (bus_if),
    .count       (count),
    .full        (full),
    .empty       (empty)
`ifdef MC_REQQ_STATS_EN
    ,
    .stat_accepted (stat_accepted),
    .stat_hiwater  (stat_hiwater),
    .stat_stall    (stat_stall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by 200000 time units");
    $fatal(1);
  end

  // One DRAM cycle: wait for the edge, then advance cycle_count and let the
  // combinational outputs settle before anything is checked.
  task automatic step();
    @(posedge clock);
    #1;
    cycle_count = cycle_count + 64'd1;
    #1;
  endtask

  task automatic do_reset();
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    cycle_count = 64'd0;
    #1;
  endtask

  // Drive an offer whose row field identifies it.
  task automatic offer(input logic [15:0] row, input logic [31:0] t, input logic [3:0] core,
                       input logic [1:0] op);
    bus_if.in_valid     = 1'b1;
    bus_if.in_core      = core;
    bus_if.in_req_time  = t;
    bus_if.in_operation = op;
    bus_if.in_address   = {row, 18'b0};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    n_checks++;
    if (count !== 5'd0 || full !== 1'b0 || bus_if.out_valid !== 1'b0)
      $display("FAIL reset_state: count=%0d full=%b out_valid=%b want 0/0/0", count, full, bus_if.out_valid);
    else n_pass++;
    n_checks++;
    if (bus_if.out_row !== 16'h0 || bus_if.out_core !== 4'h0 || bus_if.out_req_time !== 32'h0 ||
        bus_if.out_column !== 10'h0)
      $display("FAIL reset_payload: row=%h core=%h time=%h col=%h want all 0", bus_if.out_row,
               bus_if.out_core, bus_if.out_req_time, bus_if.out_column);
    else n_pass++;
    reset = 1'b0;
    cycle_count = 64'd0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (count !== 5'd0 || empty !== 1'b1 || bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0)
        $display("FAIL reset_idle cyc%0d: count=%0d empty=%b in_ready=%b out_valid=%b want 0/1/1/0",
                 i, count, empty, bus_if.in_ready, bus_if.out_valid);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_push_decode();
    do_reset();
    step();   // cycle_count = 1
    bus_if.in_valid     = 1'b1;
    bus_if.in_core      = 4'd3;
    bus_if.in_req_time  = 32'd5;
    bus_if.in_operation = RD;
    bus_if.in_address   = 34'h3_0000_1A84;
    step();   // cycle_count = 2, entry now stored
    bus_if.in_valid = 1'b0;
    n_checks++;
    if (count !== 5'd1) $display("FAIL push_count: count=%0d want 1", count);
    else n_pass++;
    while (cycle_count < 64'd7) begin
      n_checks++;
      if (bus_if.out_valid !== 1'b0)
        $display("FAIL early_valid at cycle %0d: out_valid=%b want 0", cycle_count, bus_if.out_valid);
      else n_pass++;
      step();
    end
    n_checks++;
    if (bus_if.out_valid !== 1'b1) $display("FAIL valid_at_7: out_valid=%b want 1", bus_if.out_valid);
    else n_pass++;
    // 34'h3_0000_1A84: bits 33,32 set -> row C000; bits 12,11,9,7,2 set ->
    // bank=[11:10]=2, bg=[9:7]=5, ch=bit6=0, column={000001,0001}=10'h011.
    n_checks++;
    if (bus_if.out_row !== 16'hC000 || bus_if.out_bank_group !== 3'h5 || bus_if.out_bank !== 2'h2)
      $display("FAIL decode_rbg: row=%h bg=%h bank=%h want C000/5/2", bus_if.out_row,
               bus_if.out_bank_group, bus_if.out_bank);
    else n_pass++;
    n_checks++;
    if (bus_if.out_channel !== 1'b0 || bus_if.out_column !== 10'h011)
      $display("FAIL decode_col: ch=%b col=%h want 0/011", bus_if.out_channel, bus_if.out_column);
    else n_pass++;
    n_checks++;
    if (bus_if.out_core !== 4'd3 || bus_if.out_operation !== 2'd0 || bus_if.out_req_time !== 32'd5)
      $display("FAIL decode_meta: core=%0d op=%0d time=%0d want 3/0/5", bus_if.out_core,
               bus_if.out_operation, bus_if.out_req_time);
    else n_pass++;
    step();   // not popped: head must hold
    n_checks++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out_row !== 16'hC000 || bus_if.out_req_time !== 32'd5)
      $display("FAIL hold_stable: valid=%b row=%h time=%0d want 1/C000/5", bus_if.out_valid,
               bus_if.out_row, bus_if.out_req_time);
    else n_pass++;
    bus_if.out_ready = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
    n_checks++;
    if (empty !== 1'b1 || bus_if.out_valid !== 1'b0)
      $display("FAIL pop_single: empty=%b out_valid=%b want 1/0", empty, bus_if.out_valid);
    else n_pass++;
  endtask

  task automatic test_full();
    do_reset();
    sb.delete();
    for (int i = 0; i < 16; i++) begin
      offer(16'(i), 32'd0, 4'(i), WR);
      sb.push_back(16'(i));
      step();
    end
    offer(16'd16, 32'd0, 4'd0, WR);   // the 17th offer, left pending
    n_checks++;
    if (full !== 1'b1 || bus_if.in_ready !== 1'b0 || count !== 5'd16)
      $display("FAIL full_flags: full=%b in_ready=%b count=%0d want 1/0/16", full, bus_if.in_ready, count);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (count !== 5'd16 || bus_if.in_ready !== 1'b0)
        $display("FAIL full_hold cyc%0d: count=%0d in_ready=%b want 16/0", i, count, bus_if.in_ready);
      else n_pass++;
    end
    n_checks++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out_row !== sb[0])
      $display("FAIL full_head: valid=%b row=%0d want 1/%0d", bus_if.out_valid, bus_if.out_row, sb[0]);
    else n_pass++;
    void'(sb.pop_front());
    bus_if.out_ready = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
    n_checks++;
    if (count !== 5'd15 || bus_if.in_ready !== 1'b1)
      $display("FAIL after_pop: count=%0d in_ready=%b want 15/1", count, bus_if.in_ready);
    else n_pass++;
    step();
    bus_if.in_valid = 1'b0;
    sb.push_back(16'd16);
    n_checks++;
    if (count !== 5'd16) $display("FAIL refill_17th: count=%0d want 16", count);
    else n_pass++;
  endtask

  // Continues from a full queue. A full queue refuses a push even in a
  // popping cycle, so refills alternate pop and push; afterwards both are
  // held together and the count settles one below full.
  task automatic test_back_to_back();
    int exp_count;
    bit w;
    next_row = 17;
    for (int k = 0; k < 40; k++) begin
      n_checks++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_row !== sb[0])
        $display("FAIL order_alt %0d: valid=%b row=%0d want 1/%0d", k, bus_if.out_valid, bus_if.out_row, sb[0]);
      else n_pass++;
      void'(sb.pop_front());
      bus_if.out_ready = 1'b1;
      step();
      bus_if.out_ready = 1'b0;
      offer(16'(next_row), 32'(k), 4'(k), RD);
      sb.push_back(16'(next_row));
      next_row++;
      step();
      bus_if.in_valid = 1'b0;
      n_checks++;
      if (count !== 5'd16) $display("FAIL count_alt %0d: count=%0d want 16", k, count);
      else n_pass++;
    end
    exp_count = 16;
    for (int c = 0; c < 10; c++) begin
      offer(16'(next_row), 32'd1, 4'd9, IFETCH);
      bus_if.out_ready = 1'b1;
      n_checks++;
      if (bus_if.out_row !== sb[0] || count !== 5'(exp_count))
        $display("FAIL simul %0d: row=%0d count=%0d want %0d/%0d", c, bus_if.out_row, count, sb[0], exp_count);
      else n_pass++;
      w = (exp_count < 16);
      void'(sb.pop_front());
      if (w) begin
        sb.push_back(16'(next_row));
        next_row++;
      end
      exp_count = w ? exp_count : exp_count - 1;
      step();
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    n_checks++;
    if (count !== 5'd15) $display("FAIL simul_end: count=%0d want 15", count);
    else n_pass++;
  endtask

  task automatic test_head_blocking();
    do_reset();
    step();
    offer(16'd1, 32'd100, 4'd1, RD);
    step();
    offer(16'd2, 32'd10, 4'd2, RD);
    step();
    bus_if.in_valid = 1'b0;
    n_checks++;
    if (count !== 5'd2) $display("FAIL block_count: count=%0d want 2", count);
    else n_pass++;
    while (cycle_count < 64'd102) begin
      n_checks++;
      if (bus_if.out_valid !== 1'b0)
        $display("FAIL blocked at cycle %0d: out_valid=%b want 0", cycle_count, bus_if.out_valid);
      else n_pass++;
      step();
    end
    n_checks++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out_req_time !== 32'd100 || bus_if.out_core !== 4'd1)
      $display("FAIL release_102: valid=%b time=%0d core=%0d want 1/100/1", bus_if.out_valid,
               bus_if.out_req_time, bus_if.out_core);
    else n_pass++;
    bus_if.out_ready = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
    n_checks++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out_req_time !== 32'd10 || bus_if.out_core !== 4'd2)
      $display("FAIL second_head: valid=%b time=%0d core=%0d want 1/10/2", bus_if.out_valid,
               bus_if.out_req_time, bus_if.out_core);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      offer(16'(i + 40), 32'd0, 4'd5, 2'd3);
      step();
    end
    bus_if.in_valid = 1'b0;
    n_checks++;
    if (count !== 5'd9 || bus_if.out_valid !== 1'b1 || bus_if.out_operation !== 2'd3 ||
        bus_if.out_row !== 16'd40)
      $display("FAIL pre_reset: count=%0d valid=%b op=%0d row=%0d want 9/1/3/40", count,
               bus_if.out_valid, bus_if.out_operation, bus_if.out_row);
    else n_pass++;
    #1;
    reset = 1'b1;   // mid-cycle, no clock edge before the checks below
    #1;
    n_checks++;
    if (count !== 5'd0 || bus_if.out_valid !== 1'b0 || empty !== 1'b1 || bus_if.in_ready !== 1'b1)
      $display("FAIL async_reset: count=%0d valid=%b empty=%b in_ready=%b want 0/0/1/1", count,
               bus_if.out_valid, empty, bus_if.in_ready);
    else n_pass++;
    n_checks++;
    if (bus_if.out_row !== 16'h0 || bus_if.out_operation !== 2'd0 || bus_if.out_core !== 4'h0)
      $display("FAIL async_payload: row=%h op=%0d core=%0d want 0/0/0", bus_if.out_row,
               bus_if.out_operation, bus_if.out_core);
    else n_pass++;
    step();
    reset = 1'b0;
    step();
    n_checks++;
    if (count !== 5'd0 || bus_if.out_valid !== 1'b0)
      $display("FAIL post_reset: count=%0d valid=%b want 0/0", count, bus_if.out_valid);
    else n_pass++;
  endtask

`ifdef MC_REQQ_STATS_EN
  task automatic test_stats();
    do_reset();
    n_checks++;
    if (stat_accepted !== 64'd0 || stat_hiwater !== 5'd0 || stat_stall !== 32'd0)
      $display("FAIL stats_reset: acc=%0d hw=%0d stall=%0d want 0/0/0", stat_accepted, stat_hiwater, stat_stall);
    else n_pass++;
    // 20 consecutive offers: 16 taken, the last 4 cycles blocked.
    for (int i = 0; i < 20; i++) begin
      offer(16'(i), 32'd0, 4'd1, WR);
      step();
    end
    bus_if.in_valid = 1'b0;
    n_checks++;
    if (stat_accepted !== 64'd16) $display("FAIL stat_accepted: got %0d want 16", stat_accepted);
    else n_pass++;
    n_checks++;
    if (stat_hiwater !== 5'd16) $display("FAIL stat_hiwater: got %0d want 16", stat_hiwater);
    else n_pass++;
    n_checks++;
    if (stat_stall !== 32'd4) $display("FAIL stat_stall: got %0d want 4", stat_stall);
    else n_pass++;
  endtask
`endif

  initial begin
    reset                 = 1'b1;
    cycle_count           = 64'd0;
    bus_if.in_valid       = 1'b0;
    bus_if.out_ready      = 1'b0;
    bus_if.in_core        = 4'd0;
    bus_if.in_req_time    = 32'd0;
    bus_if.in_operation   = 2'd0;
    bus_if.in_address     = 34'd0;
    test_reset();
    test_push_decode();
    test_full();
    test_back_to_back();
    test_head_blocking();
    test_async_reset();
`ifdef MC_REQQ_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
